decode_reg_block: RTL and testbench

//  Y86-64 SEQ decode + write-back stage around the 15-entry program register file.

---
 rtl/y86_pkg.sv | 27 ++
 rtl/y86_regfile.sv | 41 ++++
 rtl/decode_reg_block.sv | 108 ++++++++++
 tb/tb_decode_reg_block.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs and data types
// used by the decode/write-back slice.
package y86_pkg;

    localparam int DATA_W = 64;
    localparam int NREGS  = 15;

    typedef logic [3:0]        reg_id_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam reg_id_t RNONE = 4'hF;
    localparam reg_id_t RRSP  = 4'h4;

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 program register file: 15 x DATA_W, asynchronous clear, two combinational
// read ports (ID 15 reads as zero) and two write ports with port M taking priority.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  reg_id_t           raddr_a,
    input  reg_id_t           raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we_e,
    input  reg_id_t           waddr_e,
    input  logic [DATA_W-1:0] wdata_e,
    input  logic              we_m,
    input  reg_id_t           waddr_m,
    input  logic [DATA_W-1:0] wdata_m
);

    localparam reg_id_t LAST_ID = reg_id_t'(NREGS - 1);

    logic [DATA_W-1:0] regs [NREGS];

    // NOTE: the whole array is cleared by reset, so it must map to flops rather
    // than a RAM macro; state updates use <= so the M write can override the E write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (we_e && waddr_e <= LAST_ID) regs[waddr_e] <= wdata_e;
            if (we_m && waddr_m <= LAST_ID) regs[waddr_m] <= wdata_m;
        end
    end

    assign rdata_a = (raddr_a <= LAST_ID) ? regs[raddr_a] : '0;
    assign rdata_b = (raddr_b <= LAST_ID) ? regs[raddr_b] : '0;

endmodule

// File: rtl/decode_reg_block.sv
// Y86-64 SEQ decode + write-back stage: source/destination decode, reg_error check and
// the register file. Define REG_BYPASS_EN to forward incoming valE/valM onto valA/valB.
module decode_reg_block
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15,
    parameter int RSP_ID = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              reg_error
);

    localparam reg_id_t RSP = reg_id_t'(RSP_ID);

    reg_id_t src_a, src_b, dst_e, dst_m;
    logic    need_ra, need_rb, ifun_bad, wr_ok;
    logic [DATA_W-1:0] rd_a, rd_b;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        src_a   = RNONE;
        src_b   = RNONE;
        dst_e   = RNONE;
        dst_m   = RNONE;
        need_ra = 1'b0;
        need_rb = 1'b0;
        case (icode)
            IRRMOVQ: begin src_a = rA; dst_e = rB; need_ra = 1'b1; need_rb = 1'b1; end
            IIRMOVQ: begin dst_e = rB; need_rb = 1'b1; end
            IRMMOVQ: begin src_a = rA; src_b = rB; need_ra = 1'b1; need_rb = 1'b1; end
            IMRMOVQ: begin src_b = rB; dst_m = rA; need_ra = 1'b1; need_rb = 1'b1; end
            IOPQ: begin
                src_a = rA; src_b = rB; dst_e = rB;
                need_ra = 1'b1; need_rb = 1'b1;
            end
            ICALL:  begin src_b = RSP; dst_e = RSP; end
            IRET:   begin src_a = RSP; src_b = RSP; dst_e = RSP; end
            IPUSHQ: begin src_a = rA; src_b = RSP; dst_e = RSP; need_ra = 1'b1; end
            IPOPQ: begin
                src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = rA;
                need_ra = 1'b1;
            end
            default: ;
        endcase
    end

    // cmovXX shares rrmovq decode; its condition arrives already folded into write_enable.
    always_comb begin
        case (icode)
            IRRMOVQ, IJXX: ifun_bad = (ifun > 4'd6);
            IOPQ:          ifun_bad = (ifun > 4'd3);
            default:       ifun_bad = (ifun != 4'd0);
        endcase
    end

    assign reg_error = (icode > IPOPQ) || ifun_bad
                    || (need_ra && rA == RNONE) || (need_rb && rB == RNONE);

    assign wr_ok = write_enable && !reg_error;

    y86_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (src_a),
        .raddr_b (src_b),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .we_e    (wr_ok && dst_e != RNONE),
        .waddr_e (dst_e),
        .wdata_e (valE),
        .we_m    (wr_ok && dst_m != RNONE),
        .waddr_m (dst_m),
        .wdata_m (valM)
    );

`ifdef REG_BYPASS_EN
    always_comb begin
        valA = rd_a;
        valB = rd_b;
        if (wr_ok && src_a != RNONE) begin
            if (src_a == dst_m)      valA = valM;
            else if (src_a == dst_e) valA = valE;
        end
        if (wr_ok && src_b != RNONE) begin
            if (src_b == dst_m)      valB = valM;
            else if (src_b == dst_e) valB = valE;
        end
    end
`else
    assign valA = rd_a;
    assign valB = rd_b;
`endif

endmodule

// File: tb/tb_decode_reg_block.sv
// Directed self-checking bench for decode_reg_block: decode, write-back, priority,
// reg_error cases and asynchronous reset.
module tb_decode_reg_block;

    logic        clk;
    logic        rst_n;
    logic [3:0]  icode, ifun, rA, rB;
    logic        write_enable;
    logic [63:0] valE, valM, valA, valB;
    logic        reg_error;

    int n_cmp = 0;
    int n_bad = 0;

    decode_reg_block dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .icode        (icode),
        .ifun         (ifun),
        .rA           (rA),
        .rB           (rB),
        .write_enable (write_enable),
        .valE         (valE),
        .valM         (valM),
        .valA         (valA),
        .valB         (valB),
        .reg_error    (reg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic we, input logic [63:0] ve,
                         input logic [63:0] vm);
        icode = ic; ifun = fn; rA = ra; rB = rb;
        write_enable = we; valE = ve; valM = vm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 64'd0, 64'd0);
        #1;
        n_cmp++;
        if (valA !== 64'd0 || valB !== 64'd0 || reg_error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out: valA=%0h valB=%0h reg_error=%0b, want 0/0/0",
                     valA, valB, reg_error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(4'h6, 4'h0, 4'(i), 4'(i), 1'b0, 64'd0, 64'd0);
            #1;
            n_cmp++;
            if (valA !== 64'd0 || valB !== 64'd0) begin
                n_bad++;
                $display("FAIL reset_reg%0d: valA=%0h valB=%0h, want 0", i, valA, valB);
            end
        end
    endtask

    task automatic test_irmovq_opq();
        drive(4'h3, 4'h0, 4'hF, 4'h7, 1'b1, 64'd10, 64'd0);
        tick();
        drive(4'h6, 4'h0, 4'h7, 4'h7, 1'b0, 64'd0, 64'd0);
        #1;
        n_cmp++;
        if (valA !== 64'd10 || valB !== 64'd10) begin
            n_bad++;
            $display("FAIL irmovq_opq: valA=%0d valB=%0d, want 10/10", valA, valB);
        end
    endtask

    task automatic test_mrmovq_pushq();
        drive(4'h5, 4'h0, 4'h3, 4'h5, 1'b1, 64'd0, 64'd102);
        tick();
        drive(4'hA, 4'h0, 4'h3, 4'hF, 1'b0, 64'd0, 64'd0);
        #1;
        n_cmp++;
        if (valA !== 64'd102 || valB !== 64'd0) begin
            n_bad++;
            $display("FAIL mrmovq_pushq: valA=%0d valB=%0d, want 102/0", valA, valB);
        end
    endtask

    task automatic test_popq_rsp();
        drive(4'hB, 4'h0, 4'h4, 4'hF, 1'b1, 64'd1, 64'd92);
        tick();
        drive(4'h9, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
        #1;
        n_cmp++;
        if (valA !== 64'd92 || valB !== 64'd92) begin
            n_bad++;
            $display("FAIL popq_m_priority: valA=%0d valB=%0d, want 92/92", valA, valB);
        end
    endtask

    task automatic test_no_write();
        drive(4'h3, 4'h0, 4'hF, 4'h9, 1'b0, 64'd109, 64'd0);
        tick();
        drive(4'h6, 4'h0, 4'h9, 4'h9, 1'b0, 64'd0, 64'd0);
        #1;
        n_cmp++;
        if (valA !== 64'd0) begin
            n_bad++;
            $display("FAIL we_low_no_write: valA=%0d, want 0", valA);
        end
        // halt never reads even though R7 holds 10
        drive(4'h0, 4'h0, 4'h7, 4'h7, 1'b0, 64'd0, 64'd0);
        #1;
        n_cmp++;
        if (valA !== 64'd0 || valB !== 64'd0) begin
            n_bad++;
            $display("FAIL halt_no_read: valA=%0d valB=%0d, want 0/0", valA, valB);
        end
    endtask

    // {icode, ifun, rA, rB, expected reg_error}
    localparam logic [16:0] ERR_TAB [16] = '{
        {4'hC, 4'h0, 4'h0, 4'h0, 1'b1}, {4'h6, 4'h3, 4'hF, 4'h3, 1'b1},
        {4'h1, 4'h1, 4'hF, 4'hF, 1'b1}, {4'h2, 4'h6, 4'h1, 4'h2, 1'b0},
        {4'h2, 4'h7, 4'h1, 4'h2, 1'b1}, {4'h6, 4'h4, 4'h1, 4'h2, 1'b1},
        {4'h7, 4'h6, 4'hF, 4'hF, 1'b0}, {4'h7, 4'h7, 4'hF, 4'hF, 1'b1},
        {4'h3, 4'h0, 4'hF, 4'h2, 1'b0}, {4'h3, 4'h0, 4'h1, 4'hF, 1'b1},
        {4'h4, 4'h0, 4'hF, 4'h1, 1'b1}, {4'h9, 4'h0, 4'hF, 4'hF, 1'b0},
        {4'hB, 4'h0, 4'hF, 4'hF, 1'b1}, {4'h8, 4'h0, 4'hF, 4'hF, 1'b0},
        {4'hA, 4'h0, 4'hF, 4'hF, 1'b1}, {4'h6, 4'h3, 4'h1, 4'h2, 1'b0}
    };

    task automatic test_reg_error();
        logic [16:0] v;
        for (int i = 0; i < 16; i++) begin
            v = ERR_TAB[i];
            drive(v[16:13], v[12:9], v[8:5], v[4:1], 1'b0, 64'd0, 64'd0);
            #1;
            n_cmp++;
            if (reg_error !== v[0]) begin
                n_bad++;
                $display("FAIL reg_error_vec%0d: ic=%0h fn=%0h rA=%0h rB=%0h got %0b want %0b",
                         i, v[16:13], v[12:9], v[8:5], v[4:1], reg_error, v[0]);
            end
        end
        // irmovq with bad ifun must not write R2
        drive(4'h3, 4'h1, 4'hF, 4'h2, 1'b1, 64'd55, 64'd0);
        tick();
        drive(4'h6, 4'h0, 4'h2, 4'h2, 1'b0, 64'd0, 64'd0);
        #1;
        n_cmp++;
        if (valA !== 64'd0) begin
            n_bad++;
            $display("FAIL err_blocks_write_r2: valA=%0d, want 0", valA);
        end
        // opq with rA=F must not write R3 (holds 102)
        drive(4'h6, 4'h3, 4'hF, 4'h3, 1'b1, 64'd77, 64'd0);
        tick();
        drive(4'h6, 4'h0, 4'h3, 4'h3, 1'b0, 64'd0, 64'd0);
        #1;
        n_cmp++;
        if (valA !== 64'd102) begin
            n_bad++;
            $display("FAIL err_blocks_write_r3: valA=%0d, want 102", valA);
        end
    endtask

    task automatic test_back_to_back();
        drive(4'h2, 4'h0, 4'h7, 4'h8, 1'b1, 64'd33, 64'd0);
        tick();
        drive(4'h2, 4'h3, 4'h8, 4'h9, 1'b1, 64'd44, 64'd0);
        tick();
        drive(4'h6, 4'h0, 4'h8, 4'h9, 1'b0, 64'd0, 64'd0);
        #1;
        n_cmp++;
        if (valA !== 64'd33 || valB !== 64'd44) begin
            n_bad++;
            $display("FAIL back_to_back: valA=%0d valB=%0d, want 33/44", valA, valB);
        end
    endtask

    task automatic test_async_reset();
        drive(4'h3, 4'h0, 4'hF, 4'h5, 1'b1, 64'h55, 64'd0);
        tick();
        drive(4'h6, 4'h0, 4'h5, 4'h3, 1'b0, 64'd0, 64'd0);
        #1;
        n_cmp++;
        if (valA !== 64'h55 || valB !== 64'd102) begin
            n_bad++;
            $display("FAIL pre_reset: valA=%0h valB=%0d, want 55/102", valA, valB);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (valA !== 64'd0 || valB !== 64'd0) begin
            n_bad++;
            $display("FAIL async_clear: valA=%0h valB=%0h, want 0/0", valA, valB);
        end
        drive(4'h3, 4'h0, 4'hF, 4'h6, 1'b1, 64'h66, 64'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h6, 4'h0, 4'h6, 4'h6, 1'b0, 64'd0, 64'd0);
        #1;
        n_cmp++;
        if (valA !== 64'd0) begin
            n_bad++;
            $display("FAIL write_in_reset: valA=%0h, want 0", valA);
        end
    endtask

    initial begin
        test_reset();
        test_irmovq_opq();
        test_mrmovq_pushq();
        test_popq_rsp();
        test_no_write();
        test_reg_error();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
